// File: rtl/sdcram_arb_pkg.sv
// Shared definitions for the two-port SDCRAM arbiter: FSM encoding,
// default bus widths, requester count and a one-hot decode helper.
package sdcram_arb_pkg;

    localparam int N_REQ      = 2;
    localparam int IDX_W      = $clog2(N_REQ);
    localparam int WEN_W      = 4;
    localparam int ADDR_W_DEF = 41;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Convert a one-hot requester vector to its index (0 when empty).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdcram_arb_rr.sv
// Round-robin grant: the search starts just after the last-served
// requester, so a requester that was just served yields to the other.
module sdcram_arb_rr
    import sdcram_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant
);

    // Rotating-priority search for the first active requester after last
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        logic             found_v;
        grant   = {N_REQ{1'b0}};
        found_v = 1'b0;
        idx_v   = {IDX_W{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            idx_v = IDX_W'((int'(last) + i) % N_REQ);
            if (!found_v && req[idx_v]) begin
                grant[idx_v] = 1'b1;
                found_v      = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/sdcram_arbiter.sv
// Two-requester arbiter in front of a single SDCRAM user port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with an
// optional WAIT-cycle timeout that completes the access with an error.
module sdcram_arbiter
    import sdcram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd1048576,
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          DATA_W  = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_ren,
    input  logic [WEN_W-1:0]  p0_wen,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    output logic              p0_err,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_ren,
    input  logic [WEN_W-1:0]  p1_wen,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_ren,
    output logic [WEN_W-1:0]  m_wen,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_busy,
    output logic [N_REQ-1:0]  o_grant
);

    localparam bit          TIMEOUT_EN = (TIMEOUT != 32'd0);
    localparam logic [31:0] TO_LAST    = TIMEOUT_EN ? 32'(TIMEOUT - 32'd1) : 32'd0;

    logic [1:0]        rst_sync_r;
    logic              rst_n_s;
    state_t            state_r;
    logic [IDX_W-1:0]  owner_r;
    logic [IDX_W-1:0]  last_r;
    logic [N_REQ-1:0]  grant_r;
    logic [31:0]       wait_cnt_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic              m_ren_r;
    logic [WEN_W-1:0]  m_wen_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [DATA_W-1:0] p_rdata_r [N_REQ];
    logic [N_REQ-1:0]  p_ack_r;
    logic [N_REQ-1:0]  p_err_r;

    logic [N_REQ-1:0]  req_s;
    logic [N_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]  gidx_s;
    logic [ADDR_W-1:0] req_addr_s  [N_REQ];
    logic [DATA_W-1:0] req_wdata_s [N_REQ];
    logic [WEN_W-1:0]  req_wen_s   [N_REQ];
    logic              req_ren_s   [N_REQ];
    logic              timeout_hit_s;

    assign req_addr_s[0]  = p0_addr;
    assign req_addr_s[1]  = p1_addr;
    assign req_wdata_s[0] = p0_wdata;
    assign req_wdata_s[1] = p1_wdata;
    assign req_wen_s[0]   = p0_wen;
    assign req_wen_s[1]   = p1_wen;
    assign req_ren_s[0]   = p0_ren;
    assign req_ren_s[1]   = p1_ren;
    assign req_s          = {p1_ren | (|p1_wen), p0_ren | (|p0_wen)};
    assign gidx_s         = onehot_to_idx(grant_s);
    assign timeout_hit_s  = TIMEOUT_EN && (wait_cnt_r == TO_LAST);
    assign rst_n_s        = rst_sync_r[1];

    sdcram_arb_rr u_rr (
        .req   (req_s),
        .last  (last_r),
        .grant (grant_s)
    );

    // Reset synchronizer: asserts asynchronously, releases after two edges
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r    <= ST_IDLE;
            owner_r    <= {IDX_W{1'b0}};
            last_r     <= IDX_W'(N_REQ - 1);
            grant_r    <= {N_REQ{1'b0}};
            wait_cnt_r <= 32'd0;
            m_addr_r   <= {ADDR_W{1'b0}};
            m_ren_r    <= 1'b0;
            m_wen_r    <= {WEN_W{1'b0}};
            m_wdata_r  <= {DATA_W{1'b0}};
            p_ack_r    <= {N_REQ{1'b0}};
            p_err_r    <= {N_REQ{1'b0}};
            for (int i = 0; i < N_REQ; i++) begin
                p_rdata_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            p_ack_r <= {N_REQ{1'b0}};
            p_err_r <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!m_busy && (|req_s)) begin
                        state_r   <= ST_ISSUE;
                        owner_r   <= gidx_s;
                        last_r    <= gidx_s;
                        grant_r   <= grant_s;
                        m_addr_r  <= req_addr_s[gidx_s];
                        m_wdata_r <= req_wdata_s[gidx_s];
                        m_wen_r   <= req_wen_s[gidx_s];
                        // Any byte enable makes it a write, whatever ren says
                        m_ren_r   <= (req_wen_s[gidx_s] == {WEN_W{1'b0}}) && req_ren_s[gidx_s];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= 32'd0;
                end
                ST_WAIT: begin
                    if (!m_busy) begin
                        state_r <= ST_DONE;
                        m_ren_r <= 1'b0;
                        m_wen_r <= {WEN_W{1'b0}};
                        if (m_ren_r) begin
                            p_rdata_r[owner_r] <= m_rdata;
                        end else begin
                            p_rdata_r[owner_r] <= p_rdata_r[owner_r];
                        end
                        p_ack_r[owner_r] <= 1'b1;
                    end else if (timeout_hit_s) begin
                        state_r            <= ST_DONE;
                        m_ren_r            <= 1'b0;
                        m_wen_r            <= {WEN_W{1'b0}};
                        p_rdata_r[owner_r] <= {DATA_W{1'b0}};
                        p_ack_r[owner_r]   <= 1'b1;
                        p_err_r[owner_r]   <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    grant_r <= {N_REQ{1'b0}};
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign m_addr   = m_addr_r;
    assign m_ren    = m_ren_r;
    assign m_wen    = m_wen_r;
    assign m_wdata  = m_wdata_r;
    assign p0_rdata = p_rdata_r[0];
    assign p1_rdata = p_rdata_r[1];
    assign p0_ack   = p_ack_r[0];
    assign p1_ack   = p_ack_r[1];
    assign p0_err   = p_err_r[0];
    assign p1_err   = p_err_r[1];
    assign o_grant  = grant_r;

endmodule

// File: tb/tb_sdcram_arbiter.sv
// Scoreboard bench for sdcram_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares them. A second instance with
// TIMEOUT=8 exercises the timeout path.
module tb_sdcram_arbiter;
    import sdcram_arb_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic [40:0] p0_addr, p1_addr;
    logic        p0_ren, p1_ren;
    logic [3:0]  p0_wen, p1_wen;
    logic [31:0] p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [40:0] m_addr;
    logic        m_ren;
    logic [3:0]  m_wen;
    logic [31:0] m_wdata, m_rdata;
    logic        m_busy;
    logic [1:0]  o_grant;

    // timeout instance signals
    logic        t_ren, t_busy;
    logic [40:0] t_addr;
    logic [31:0] t_m_rdata;
    logic [31:0] t_p0_rdata, t_p1_rdata;
    logic        t_p0_ack, t_p1_ack, t_p0_err, t_p1_err;
    logic [40:0] t_m_addr;
    logic        t_m_ren;
    logic [3:0]  t_m_wen;
    logic [31:0] t_m_wdata;
    logic [1:0]  t_grant;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    sdcram_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_addr(p0_addr), .p0_ren(p0_ren), .p0_wen(p0_wen), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_addr(p1_addr), .p1_ren(p1_ren), .p1_wen(p1_wen), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_busy(m_busy), .o_grant(o_grant)
    );

    sdcram_arbiter #(.TIMEOUT(8)) dut_to (
        .CLK(CLK), .RST_N(RST_N),
        .p0_addr(t_addr), .p0_ren(t_ren), .p0_wen(4'h0), .p0_wdata(32'h0),
        .p0_rdata(t_p0_rdata), .p0_ack(t_p0_ack), .p0_err(t_p0_err),
        .p1_addr(41'h0), .p1_ren(1'b0), .p1_wen(4'h0), .p1_wdata(32'h0),
        .p1_rdata(t_p1_rdata), .p1_ack(t_p1_ack), .p1_err(t_p1_err),
        .m_addr(t_m_addr), .m_ren(t_m_ren), .m_wen(t_m_wen), .m_wdata(t_m_wdata),
        .m_rdata(t_m_rdata), .m_busy(t_busy), .o_grant(t_grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Wait for an ack on the given port, then step past the DONE edge
    task automatic wait_ack(input int port, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge CLK);
            seen = (port == 1) ? p1_ack : p0_ack;
        end
        chk($sformatf("ack_p%0d_within_budget", port), 64'(seen), 64'd1);
        @(posedge CLK); #1;
    endtask

    // Monitor: every ack is matched against the oldest expected response
    always @(negedge CLK) begin
        if (p0_ack || p1_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'({p1_ack, p0_ack}), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_port", 64'({p1_ack, p0_ack}), (e.port == 1) ? 64'd2 : 64'd1);
                chk("ack_err", 64'({p1_err, p0_err}), e.err ? ((e.port == 1) ? 64'd2 : 64'd1) : 64'd0);
                chk("ack_rdata", 64'((e.port == 1) ? p1_rdata : p0_rdata), 64'(e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq[$];
        bit done, drop0, drop1, early, accepted;
        int n;

        RST_N = 1'b1;
        p0_addr = 41'h0; p0_ren = 1'b0; p0_wen = 4'h0; p0_wdata = 32'h0;
        p1_addr = 41'h0; p1_ren = 1'b0; p1_wen = 4'h0; p1_wdata = 32'h0;
        m_rdata = 32'h0; m_busy = 1'b0;
        t_ren = 1'b0; t_busy = 1'b0; t_addr = 41'h44; t_m_rdata = 32'h0;

        // ---------- reset state ----------
        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_m_ren", 64'(m_ren), 64'd0);
        chk("rst_m_wen", 64'(m_wen), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_acks", 64'({p1_ack, p0_ack, p1_err, p0_err}), 64'd0);
        chk("rst_rdata", 64'({p1_rdata, p0_rdata}), 64'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        repeat (4) @(posedge CLK); #1;

        // ---------- simultaneous writes after reset: p0 then p1 ----------
        p0_addr = 41'h100; p0_wdata = 32'hDEAD_0000; p0_wen = 4'hF;
        p1_addr = 41'h200; p1_wdata = 32'hBEEF_0001; p1_wen = 4'h3;
        push_exp(0, 32'h0, 1'b0);
        push_exp(1, 32'h0, 1'b0);
        @(posedge CLK); #1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (seq.size() == 0 || seq[$] != o_grant) seq.push_back(o_grant);
            drop0 = p0_ack;
            drop1 = p1_ack;
            @(posedge CLK); #1;
            if (drop0) p0_wen = 4'h0;
            if (drop1) begin p1_wen = 4'h0; done = 1'b1; end
        end
        chk("grant_seq_len", 64'(seq.size()), 64'd3);
        if (seq.size() == 3) begin
            chk("grant_seq0", 64'(seq[0]), 64'd1);
            chk("grant_seq1", 64'(seq[1]), 64'd0);
            chk("grant_seq2", 64'(seq[2]), 64'd2);
        end

        // ---------- p0 read of 0x40, minimum latency ----------
        p0_addr = 41'h40; p0_ren = 1'b1; m_busy = 1'b0;
        push_exp(0, 32'hA5A5_0001, 1'b0);
        @(posedge CLK); #1 m_rdata = 32'h1111_1111;
        @(negedge CLK);
        chk("rd_issue_m_ren", 64'(m_ren), 64'd1);
        chk("rd_issue_m_addr", 64'(m_addr), 64'h40);
        chk("rd_issue_grant", 64'(o_grant), 64'd1);
        @(posedge CLK); #1 m_rdata = 32'hA5A5_0001;
        @(negedge CLK);
        chk("rd_wait_m_ren", 64'(m_ren), 64'd1);
        @(posedge CLK); #1 m_rdata = 32'h2222_2222;
        @(negedge CLK);
        chk("rd_ack_cycle3", 64'(p0_ack), 64'd1);
        chk("rd_done_m_ren", 64'(m_ren), 64'd0);
        @(posedge CLK); #1 p0_ren = 1'b0;

        // ---------- p0 write keeps last read data ----------
        p0_addr = 41'h44; p0_wdata = 32'h0F0F_0F0F; p0_wen = 4'h5;
        push_exp(0, 32'hA5A5_0001, 1'b0);
        wait_ack(0, 10);
        p0_wen = 4'h0;

        // ---------- p1 write with ren=1, busy high for 10 WAIT cycles ----------
        p1_addr = 41'h300; p1_wdata = 32'h1234_5678; p1_wen = 4'hF; p1_ren = 1'b1;
        push_exp(1, 32'h0, 1'b0);
        @(posedge CLK); #1 m_busy = 1'b1;
        @(negedge CLK);
        chk("wr_m_ren", 64'(m_ren), 64'd0);
        chk("wr_m_wen", 64'(m_wen), 64'hF);
        chk("wr_m_wdata", 64'(m_wdata), 64'h1234_5678);
        chk("wr_grant", 64'(o_grant), 64'd2);
        early = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge CLK); #1;
            if (c == 4) begin p0_addr = 41'h7FF; p0_wen = 4'hF; end
            if (c == 6) p0_wen = 4'h0;
            if (c == 11) m_busy = 1'b0;
            @(negedge CLK);
            if (p1_ack) early = 1'b1;
            if (c == 5) begin
                chk("nonowner_m_addr", 64'(m_addr), 64'h300);
                chk("nonowner_m_wen", 64'(m_wen), 64'hF);
            end
        end
        chk("wr_no_early_ack", 64'(early), 64'd0);
        @(negedge CLK);
        chk("wr_ack_after_busy", 64'(p1_ack), 64'd1);
        @(posedge CLK); #1 p1_wen = 4'h0; p1_ren = 1'b0;

        // ---------- reset during WAIT aborts without ack ----------
        p0_addr = 41'h48; p0_ren = 1'b1; m_busy = 1'b0;
        @(posedge CLK); #1 m_busy = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("abort_m_ren", 64'(m_ren), 64'd0);
        chk("abort_m_addr", 64'(m_addr), 64'd0);
        chk("abort_m_wdata", 64'(m_wdata), 64'd0);
        chk("abort_grant", 64'(o_grant), 64'd0);
        chk("abort_p0_rdata", 64'(p0_rdata), 64'd0);
        chk("abort_acks", 64'({p1_ack, p0_ack}), 64'd0);
        p0_ren = 1'b0; m_busy = 1'b0;
        repeat (2) @(posedge CLK); #1 RST_N = 1'b1;
        repeat (4) @(posedge CLK); #1;
        p1_addr = 41'h80; p1_ren = 1'b1; m_rdata = 32'h0BAD_F00D;
        push_exp(1, 32'h0BAD_F00D, 1'b0);
        wait_ack(1, 10);
        p1_ren = 1'b0;

        // ---------- TIMEOUT=8 instance ----------
        t_ren = 1'b1; t_busy = 1'b0; t_m_rdata = 32'h55AA_55AA;
        accepted = 1'b0;
        for (int c = 0; c < 10 && !accepted; c++) begin
            @(negedge CLK);
            accepted = t_p0_ack;
        end
        chk("to_first_read_rdata", 64'(t_p0_rdata), 64'h55AA_55AA);
        @(posedge CLK); #1 t_ren = 1'b0;
        t_m_rdata = 32'hFFFF_0000;
        t_ren = 1'b1;
        @(posedge CLK); #1 t_busy = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (n < 30 && !accepted) begin
            @(negedge CLK);
            n++;
            accepted = t_p0_ack;
        end
        chk("to_ack_latency", 64'(n), 64'd10);
        chk("to_err", 64'(t_p0_err), 64'd1);
        chk("to_rdata_zero", 64'(t_p0_rdata), 64'd0);
        chk("to_m_ren_clear", 64'(t_m_ren), 64'd0);
        @(posedge CLK); #1 t_ren = 1'b0;
        @(posedge CLK); #1 t_ren = 1'b1;
        early = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (t_grant != 2'b00) early = 1'b1;
        end
        chk("to_held_while_busy", 64'(early), 64'd0);
        @(posedge CLK); #1 t_busy = 1'b0; t_m_rdata = 32'h3C3C_3C3C;
        accepted = 1'b0;
        for (int c = 0; c < 10 && !accepted; c++) begin
            @(negedge CLK);
            accepted = t_p0_ack;
        end
        chk("to_next_req_ack", 64'(accepted), 64'd1);
        chk("to_next_req_rdata", 64'(t_p0_rdata), 64'h3C3C_3C3C);
        chk("to_next_req_err", 64'(t_p0_err), 64'd0);
        @(posedge CLK); #1 t_ren = 1'b0;

        repeat (3) @(posedge CLK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
